// File: rtl/g4_table_pkg.sv
// Shared types and entry-layout constants for the G4 table update path.
// The 171-bit entry is a 160-bit rule followed by an 11-bit next_index link.
package g4_table_pkg;

   localparam int ENTRY_W = 171;
   localparam int RULE_W  = 160;
   localparam int IDX_W   = 11;
   localparam int PORT_W  = 16;

   localparam logic [IDX_W-1:0] NULL_IDX = 11'h7FF;

   localparam int SRC_IP_LSB   = 0;
   localparam int SRC_LEN_LSB  = 32;
   localparam int DST_IP_LSB   = 38;
   localparam int DST_LEN_LSB  = 70;
   localparam int SPORT_HI_LSB = 76;
   localparam int SPORT_LO_LSB = 92;
   localparam int DPORT_HI_LSB = 108;
   localparam int DPORT_LO_LSB = 124;
   localparam int PROTO_LSB    = 140;
   localparam int PROTO_WC_BIT = 148;
   localparam int RULE_ID_LSB  = 149;
   localparam int NEXT_LSB     = 160;

   // The four port bounds are contiguous, starting at sport hi.
   localparam int PORTS_W = 4 * PORT_W;

   typedef enum logic {
      OP_INSERT = 1'b0,
      OP_MODIFY = 1'b1
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_RD,
      ST_CAP,
      ST_WR_NEW,
      ST_WR_LINK,
      ST_RESP
   } state_e;

endpackage

// File: rtl/g4_rule_check.sv
// Combinational admission check for one update request: index range,
// port-range ordering and table-full detection for inserts.
module g4_rule_check
   import g4_table_pkg::*;
#(
   parameter int TABLE_ENTRY_SIZE = 29
) (
   input  logic [PORTS_W-1:0] ports_i,
   input  logic [IDX_W-1:0]   index_i,
   input  op_e                op_i,
   input  logic [IDX_W-1:0]   alloc_ptr_i,
   output logic               err_o
);

   localparam int BASE = SPORT_HI_LSB;

   logic [PORT_W-1:0] sport_hi;
   logic [PORT_W-1:0] sport_lo;
   logic [PORT_W-1:0] dport_hi;
   logic [PORT_W-1:0] dport_lo;
   logic              idx_bad;
   logic              port_bad;
   logic              full;

   assign sport_hi = ports_i[SPORT_HI_LSB-BASE +: PORT_W];
   assign sport_lo = ports_i[SPORT_LO_LSB-BASE +: PORT_W];
   assign dport_hi = ports_i[DPORT_HI_LSB-BASE +: PORT_W];
   assign dport_lo = ports_i[DPORT_LO_LSB-BASE +: PORT_W];

   assign idx_bad  = (index_i >= IDX_W'(TABLE_ENTRY_SIZE));
   assign port_bad = (sport_lo > sport_hi) || (dport_lo > dport_hi);
   assign full     = (op_i == OP_INSERT) && (alloc_ptr_i >= IDX_W'(TABLE_ENTRY_SIZE));
   assign err_o    = idx_bad | port_bad | full;

endmodule

// File: rtl/g4_table_writer.sv
// Update engine for one G4 table: bump-pointer allocation, one RAM access per
// cycle, new entry written before the anchor link so searches never see a dangling pointer.
module g4_table_writer
   import g4_table_pkg::*;
#(
   parameter int SUBSET_NUM       = 0,
   parameter int TABLE_NUM        = 0,
   parameter int TABLE_ENTRY_SIZE = 29,
   parameter int ALLOC_BASE       = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_op,
   input  logic [IDX_W-1:0]   req_index,
   input  logic [RULE_W-1:0]  req_rule,
   output logic               rsp_valid,
   output logic               rsp_err,
   output logic [IDX_W-1:0]   rsp_index,
   output logic [IDX_W-1:0]   mem_addr,
   output logic               mem_we,
   output logic [ENTRY_W-1:0] mem_din,
   input  logic [ENTRY_W-1:0] mem_dout,
   output logic [IDX_W-1:0]   alloc_ptr
);

   if (SUBSET_NUM < 0 || TABLE_NUM < 0 || ALLOC_BASE < 0 ||
       TABLE_ENTRY_SIZE < ALLOC_BASE || TABLE_ENTRY_SIZE >= (1 << IDX_W) - 1) begin : g_bad_params
      $error("g4_table_writer: illegal parameter combination");
   end

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     alloc_q, alloc_d;
   logic                 err_q, err_d;
   op_e                  op_q;
   logic [IDX_W-1:0]     idx_q;
   logic [RULE_W-1:0]    rule_q;
   logic [ENTRY_W-1:0]   old_q;
   logic                 chk_err;

   g4_rule_check #(
      .TABLE_ENTRY_SIZE(TABLE_ENTRY_SIZE)
   ) u_rule_check (
      .ports_i    (rule_q[SPORT_HI_LSB +: PORTS_W]),
      .index_i    (idx_q),
      .op_i       (op_q),
      .alloc_ptr_i(alloc_q),
      .err_o      (chk_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         alloc_q <= IDX_W'(ALLOC_BASE);
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         alloc_q <= alloc_d;
         err_q   <= err_d;
      end
   end

   // Request fields and the anchor's old image are plain data: no reset needed.
   always_ff @(posedge clk) begin
      if (req_valid && req_ready) begin
         op_q   <= op_e'(req_op);
         idx_q  <= req_index;
         rule_q <= req_rule;
      end
      if (state_q == ST_CAP) begin
         old_q <= mem_dout;
      end
   end

   always_comb begin
      state_d = state_q;
      alloc_d = alloc_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = ST_CHECK;
               err_d   = 1'b0;
            end
         end
         ST_CHECK: begin
            if (chk_err) begin
               state_d = ST_RESP;
               err_d   = 1'b1;
            end else begin
               state_d = ST_RD;
            end
         end
         ST_RD:     state_d = ST_CAP;
         ST_CAP:    state_d = ST_WR_NEW;
         ST_WR_NEW: state_d = (op_q == OP_MODIFY) ? ST_RESP : ST_WR_LINK;
         ST_WR_LINK: begin
            state_d = ST_RESP;
            if (alloc_q < IDX_W'(TABLE_ENTRY_SIZE)) begin
               alloc_d = alloc_q + 1'b1;
            end
         end
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == ST_IDLE);
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_index = '0;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_din   = '0;
      unique case (state_q)
         ST_RD: mem_addr = idx_q;
         ST_WR_NEW: begin
            mem_we   = 1'b1;
            mem_addr = (op_q == OP_MODIFY) ? idx_q : alloc_q;
            mem_din  = {old_q[NEXT_LSB +: IDX_W], rule_q};
         end
         ST_WR_LINK: begin
            mem_we   = 1'b1;
            mem_addr = idx_q;
            mem_din  = {alloc_q, old_q[RULE_W-1:0]};
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            // alloc_q has already stepped past the slot this insert filled.
            if (!err_q) begin
               rsp_index = (op_q == OP_MODIFY) ? idx_q : (alloc_q - 1'b1);
            end
         end
         default: ;
      endcase
   end

   assign alloc_ptr = alloc_q;

endmodule

// File: tb/tb_g4_table_writer.sv
// Bench for g4_table_writer: synchronous RAM model, behavioural table model with
// per-cycle output comparison, directed scenarios with literal expectations, random traffic.
module tb_g4_table_writer;

   localparam int TES   = 29;
   localparam int ABASE = 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_op = 1'b0;
   logic [10:0]  req_index = '0;
   logic [159:0] req_rule = '0;
   logic         rsp_valid, rsp_err;
   logic [10:0]  rsp_index, mem_addr, alloc_ptr;
   logic         mem_we;
   logic [170:0] mem_din, mem_dout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   g4_table_writer #(.SUBSET_NUM(0), .TABLE_NUM(0), .TABLE_ENTRY_SIZE(TES), .ALLOC_BASE(ABASE)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_index(req_index), .req_rule(req_rule),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_index(rsp_index),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
      .alloc_ptr(alloc_ptr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Table RAM: single port, read-before-write, data one cycle after address.
   logic [170:0] img [0:31];
   logic [170:0] ram [0:2047];
   logic         load = 1'b0;
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 32; i++) ram[i] <= img[i];
      end else if (mem_we) begin
         ram[mem_addr] <= mem_din;
      end
      mem_dout <= ram[mem_addr];
   end

   task automatic chk(input string nm, input logic [170:0] got, input logic [170:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", nm, got, exp);
      end
   endtask

   // Behavioural model: shadow table, allocation pointer, and the expected
   // per-cycle schedule of the transaction in flight (offset from acceptance).
   logic [170:0] gt [0:31];
   int           mptr = ABASE;
   bit           act = 1'b0;
   int           t0, lat, off;
   bit           m_err, m_ins_ok, busy, ewe;
   logic [10:0]  m_idx, m_ridx, m_new;
   logic [170:0] m_old;
   bit           exp_we [0:7];
   logic [10:0]  exp_a [0:7];
   logic [170:0] exp_d [0:7];

   always @(negedge clk) begin
      if (!rst_n) begin
         act  = 1'b0;
         mptr = ABASE;
         for (int i = 0; i < 32; i++) gt[i] = img[i];
         chk("rst_ready", req_ready, 1);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_err", rsp_err, 0);
         chk("rst_rsp_index", rsp_index, 0);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_mem_addr", mem_addr, 0);
         chk("rst_mem_din", mem_din, 0);
         chk("rst_alloc_ptr", alloc_ptr, ABASE);
      end else begin
         off = cyc - t0;
         if (act && off == lat && m_ins_ok) mptr = mptr + 1;
         busy = act && off >= 1 && off <= lat;
         chk("ready", req_ready, !busy);
         ewe = act && off <= 7 && exp_we[off];
         chk("mem_we", mem_we, ewe);
         if (ewe) begin
            chk("wr_addr", mem_addr, exp_a[off]);
            chk("wr_din", mem_din, exp_d[off]);
         end else begin
            chk("idle_din", mem_din, 0);
         end
         if (act && off == 2 && !m_err) chk("rd_addr", mem_addr, m_idx);
         chk("rsp_valid", rsp_valid, act && off == lat);
         if (act && off == lat) begin
            chk("rsp_err", rsp_err, m_err);
            if (!m_err) chk("rsp_index", rsp_index, m_ridx);
         end else begin
            chk("rsp_err_idle", rsp_err, 0);
            chk("rsp_index_idle", rsp_index, 0);
         end
         chk("alloc_ptr", alloc_ptr, mptr);
         if (act && off >= lat) act = 1'b0;
         if (!busy && req_valid) begin
            for (int k = 0; k < 8; k++) exp_we[k] = 1'b0;
            m_idx    = req_index;
            m_ins_ok = 1'b0;
            m_err = (req_index >= TES) || (req_rule[107:92] > req_rule[91:76]) ||
                    (req_rule[139:124] > req_rule[123:108]) || (!req_op && mptr >= TES);
            if (m_err) begin
               lat = 2;
            end else if (!req_op) begin
               m_old = gt[req_index];
               m_new = 11'(mptr);
               exp_we[4] = 1'b1; exp_a[4] = m_new;     exp_d[4] = {m_old[170:160], req_rule};
               exp_we[5] = 1'b1; exp_a[5] = req_index; exp_d[5] = {m_new, m_old[159:0]};
               gt[m_new]     = exp_d[4];
               gt[req_index] = exp_d[5];
               lat = 6; m_ins_ok = 1'b1; m_ridx = m_new;
            end else begin
               exp_we[4] = 1'b1; exp_a[4] = req_index;
               exp_d[4]  = {gt[req_index][170:160], req_rule};
               gt[req_index] = exp_d[4];
               lat = 5; m_ridx = req_index;
            end
            act = 1'b1;
            t0  = cyc;
         end
      end
   end

   function automatic logic [159:0] mk_rule(input logic [10:0] id, input logic [15:0] sh,
                                             input logic [15:0] sl, input logic [15:0] dh,
                                             input logic [15:0] dl);
      logic [159:0] r;
      r = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C, 32'h4B5A_6978, 32'h8796_A5B4};
      r[91:76] = sh; r[107:92] = sl; r[123:108] = dh; r[139:124] = dl;
      r[159:149] = id;
      return r;
   endfunction

   function automatic logic [159:0] rand_rule(input bit good);
      logic [159:0] r;
      logic [15:0]  a, b, c, d;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      if (good) begin
         r[91:76]   = (a > b) ? a : b;  r[107:92]  = (a > b) ? b : a;
         r[123:108] = (c > d) ? c : d;  r[139:124] = (c > d) ? d : c;
      end
      return r;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; load = 1'b1; req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 load = 1'b0; rst_n = 1'b1;
   endtask

   task automatic do_req(input bit op, input logic [10:0] idx, input logic [159:0] rule,
                         output int rlat, output bit rerr, output logic [10:0] ridx, output int wes);
      bit got;
      int k;
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = op; req_index = idx; req_rule = rule;
      k = 0;
      while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      got = 1'b0; rlat = 0; rerr = 1'b0; ridx = '0; wes = 0;
      for (int n = 1; n <= 20 && !got; n++) begin
         @(negedge clk);
         if (mem_we) wes++;
         if (rsp_valid) begin got = 1'b1; rlat = n; rerr = rsp_err; ridx = rsp_index; end
      end
      if (!got) chk("rsp_timeout", 0, 1);
      #1;
   endtask

   logic [159:0] r1, r2, r3;
   int           lt, we_n;
   bit           er;
   logic [10:0]  ri;

   initial begin
      img[0] = {11'h7FF, 160'hA5A5};
      for (int i = 1; i < 32; i++) img[i] = {11'($urandom), rand_rule(1'b1)};
      do_reset();

      // Tail append onto a NULL-terminated head.
      r1 = mk_rule(11'h001, 16'h1000, 16'h0010, 16'h2000, 16'h0020);
      do_req(1'b0, 11'd0, r1, lt, er, ri, we_n);
      chk("t1_lat", lt, 6); chk("t1_err", er, 0); chk("t1_idx", ri, 1);
      chk("t1_new", ram[1], {11'h7FF, r1});
      chk("t1_link", ram[0], {11'd1, 160'hA5A5});
      chk("t1_ptr", alloc_ptr, 2); chk("t1_model_ptr", mptr, 2);

      // Insert between head and existing successor.
      r2 = mk_rule(11'h002, 16'hFFFF, 16'h0000, 16'h0100, 16'h0100);
      do_req(1'b0, 11'd0, r2, lt, er, ri, we_n);
      chk("t2_lat", lt, 6); chk("t2_idx", ri, 2);
      chk("t2_new", ram[2], {11'd1, r2});
      chk("t2_link", ram[0][170:160], 2);

      // Modify keeps the link.
      r3 = r1; r3[159:149] = 11'h05A;
      do_req(1'b1, 11'd1, r3, lt, er, ri, we_n);
      chk("t3_lat", lt, 5); chk("t3_err", er, 0); chk("t3_wes", we_n, 1);
      chk("t3_entry", ram[1], {11'h7FF, r3});
      chk("t3_ptr", alloc_ptr, 3);

      // Rejections: inverted sport range, out-of-range index.
      do_req(1'b0, 11'd0, mk_rule(11'h3, 16'h0010, 16'h0050, 16'h10, 16'h1), lt, er, ri, we_n);
      chk("t4a_lat", lt, 2); chk("t4a_err", er, 1); chk("t4a_wes", we_n, 0);
      do_req(1'b0, 11'd29, r1, lt, er, ri, we_n);
      chk("t4b_lat", lt, 2); chk("t4b_err", er, 1); chk("t4b_wes", we_n, 0);
      chk("t4_ptr", alloc_ptr, 3);

      // Fill to the last slot, then overflow.
      while (alloc_ptr < 28) do_req(1'b0, 11'($urandom_range(0, 27)), rand_rule(1'b1), lt, er, ri, we_n);
      chk("t5_pre_ptr", alloc_ptr, 28);
      do_req(1'b0, 11'd0, r2, lt, er, ri, we_n);
      chk("t5_last_err", er, 0); chk("t5_last_idx", ri, 28); chk("t5_ptr", alloc_ptr, 29);
      do_req(1'b0, 11'd0, r2, lt, er, ri, we_n);
      chk("t5_full_err", er, 1); chk("t5_full_ptr", alloc_ptr, 29); chk("t5_model_ptr", mptr, 29);

      // Reset asserted while the anchor link is being written.
      do_reset();
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 1'b0; req_index = 11'd0; req_rule = r1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("t6_in_link_we", mem_we, 1); chk("t6_in_link_addr", mem_addr, 0);
      rst_n = 1'b0;
      #1;
      chk("t6_we", mem_we, 0); chk("t6_addr", mem_addr, 0); chk("t6_din", mem_din, 0);
      chk("t6_rsp", rsp_valid, 0); chk("t6_ptr", alloc_ptr, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("t6_ready", req_ready, 1); chk("t6_ptr_after", alloc_ptr, 1);

      // Random traffic, valid toggling freely including while busy.
      for (int round = 0; round < 2; round++) begin
         do_reset();
         for (int c = 0; c < 900; c++) begin
            @(posedge clk); #1;
            req_valid = ($urandom_range(0, 2) != 0);
            req_op    = ($urandom_range(0, 9) < 4);
            req_index = 11'($urandom_range(0, 31));
            req_rule  = rand_rule($urandom_range(0, 3) != 0);
         end
         req_valid = 1'b0;
         repeat (10) @(posedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
